// File: rtl/pipe_reg_en_pkg.sv
// Shared helpers for the elastic pipeline register slice.
// Holds the count-width function used by the interface and the top level.
package pipe_reg_en_pkg;

  // Bits needed to represent 0..depth inclusive.
  function automatic int clog2_cnt(input int depth);
    if (depth < 1) begin
      return 1;
    end
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_en_if.sv
// Handshake bundle for pipe_reg_en: upstream push, downstream pop, flush and occupancy.
interface pipe_reg_en_if
  import pipe_reg_en_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
);

  localparam int CW = clog2_cnt(DEPTH);

  // A transfer happens on a rising edge where valid and ready are both 1.
  // The producer holds valid and data stable until that edge; ready may
  // depend combinationally on the consumer's ready but never on valid.
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;

  modport master (
    output flush,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  count
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output count
  );

endinterface

// File: rtl/pipe_reg_en_stage.sv
// One elastic stage: a valid bit plus WIDTH data bits, loaded when the
// downstream ready chain says this slot may move.
module pipe_stage #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Flush outranks load and hold so a squash always empties the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (flush) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (load) begin
      valid <= src_valid;
      data  <= src_data;
    end
  end

endmodule

// File: rtl/pipe_reg_en.sv
// Elastic pipeline register: DEPTH valid-tagged stages with bubble collapse,
// synchronous flush and a registered occupancy count.
module pipe_reg_en
  import pipe_reg_en_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_reg_en_if.slave bus
);

  localparam int CW = clog2_cnt(DEPTH);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] d [DEPTH];
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             pop;

  // A stage may move if it is empty or everything ahead of it can move;
  // this makes out_ready reach in_ready combinationally when full.
  always_comb begin
    rdy = '0;
    rdy[DEPTH-1] = ~v[DEPTH-1] | bus.out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      rdy[i] = ~v[i] | rdy[i+1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             src_v;
    logic [WIDTH-1:0] src_d;

    if (g == 0) begin : g_head
      assign src_v = bus.in_valid & ~bus.flush;
      assign src_d = bus.in_data;
    end else begin : g_body
      assign src_v = v[g-1];
      assign src_d = d[g-1];
    end

    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (bus.flush),
      .load      (rdy[g]),
      .src_valid (src_v),
      .src_data  (src_d),
      .valid     (v[g]),
      .data      (d[g])
    );
  end

  assign bus.in_ready  = rdy[0] & ~bus.flush;
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data  = d[DEPTH-1];
  assign bus.count     = cnt;

  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = bus.out_valid & bus.out_ready;

  // Tracks the popcount of v without an adder tree: +1/-1 per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (bus.flush) begin
      cnt <= '0;
    end else if (accept && !pop) begin
      cnt <= cnt + CW'(1);
    end else if (pop && !accept) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_reg_en.sv
// Self-checking bench for pipe_reg_en (DEPTH=3, WIDTH=8, RESET_VAL=A5) using a
// queue-of-items reference model with per-item earliest-visible cycle.
module tb_pipe_reg_en;

  localparam int              WIDTH = 8;
  localparam int              DEPTH = 3;
  localparam int              CW    = 2;
  localparam logic [WIDTH-1:0] RV   = 8'hA5;

  logic clk;
  logic rst_n;

  pipe_reg_en_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pipe_reg_en #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (RV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int vectors;
  int miscompares;
  int edge_n;
  logic [WIDTH-1:0] exp_q[$];
  int               due_q[$];
  logic             exp_in_ready;
  logic             exp_out_valid;
  logic [WIDTH-1:0] exp_out_data;
  logic [CW-1:0]    exp_count;

  // Item is visible at the output once its age reaches DEPTH cycles and
  // everything older has left; capacity is DEPTH unless the head pops.
  task automatic model_eval();
    exp_count     = CW'(exp_q.size());
    exp_in_ready  = !bus.flush && ((exp_q.size() < DEPTH) || bus.out_ready);
    exp_out_valid = (exp_q.size() > 0) && (due_q[0] <= edge_n);
    exp_out_data  = (exp_q.size() > 0) ? exp_q[0] : RV;
  endtask

  task automatic clock_edge();
    logic             acc;
    logic             pop;
    logic [WIDTH-1:0] dat;
    model_eval();
    acc = bus.in_valid && exp_in_ready;
    pop = exp_out_valid && bus.out_ready;
    dat = bus.in_data;
    @(posedge clk);
    edge_n++;
    if (bus.flush) begin
      exp_q.delete();
      due_q.delete();
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      if (acc) begin
        exp_q.push_back(dat);
        due_q.push_back(edge_n + DEPTH - 1);
      end
    end
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [WIDTH-1:0] dat,
                       input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_data   = dat;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release in_ready: got %b want 1", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_release out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_data !== RV) begin miscompares++; $display("FAIL reset_release out_data: got %h want %h", bus.out_data, RV); end
    vectors++; if (bus.count !== 2'd0) begin miscompares++; $display("FAIL reset_release count: got %0d want 0", bus.count); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
      clock_edge();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    model_eval();
    vectors++; if (bus.count !== exp_count) begin miscompares++; $display("FAIL reset_prefill count: got %0d want %0d", bus.count, exp_count); end
    vectors++; if (bus.out_valid !== exp_out_valid) begin miscompares++; $display("FAIL reset_prefill out_valid: got %b want %b", bus.out_valid, exp_out_valid); end
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    due_q.delete();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_async out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_data !== RV) begin miscompares++; $display("FAIL reset_async out_data: got %h want %h", bus.out_data, RV); end
    vectors++; if (bus.count !== 2'd0) begin miscompares++; $display("FAIL reset_async count: got %0d want 0", bus.count); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_after in_ready: got %b want 1", bus.in_ready); end
    vectors++; if (bus.count !== 2'd0) begin miscompares++; $display("FAIL reset_after count: got %0d want 0", bus.count); end
  endtask

  task automatic test_latency_throughput();
    int first_acc;
    int first_out;
    logic [WIDTH-1:0] first_dat;
    first_acc = -1;
    first_out = -1;
    first_dat = '0;
    for (int c = 0; c < 14; c++) begin
      if (c < 6) drive(1'b1, WIDTH'(c + 1), 1'b1, 1'b0);
      else       drive(1'b0, '0, 1'b1, 1'b0);
      model_eval();
      if (first_acc < 0 && bus.in_valid && exp_in_ready) first_acc = edge_n;
      if (first_out < 0 && bus.out_valid === 1'b1) begin
        first_out = edge_n;
        first_dat = bus.out_data;
      end
      vectors++; if (bus.in_ready !== exp_in_ready) begin miscompares++; $display("FAIL lat in_ready: got %b want %b", bus.in_ready, exp_in_ready); end
      vectors++; if (bus.out_valid !== exp_out_valid) begin miscompares++; $display("FAIL lat out_valid: got %b want %b", bus.out_valid, exp_out_valid); end
      vectors++; if (bus.count !== exp_count) begin miscompares++; $display("FAIL lat count: got %0d want %0d", bus.count, exp_count); end
      if (exp_out_valid) begin
        vectors++; if (bus.out_data !== exp_out_data) begin miscompares++; $display("FAIL lat out_data: got %h want %h", bus.out_data, exp_out_data); end
      end
      clock_edge();
    end
    vectors++; if (first_out - first_acc != DEPTH) begin miscompares++; $display("FAIL lat first_latency: got %0d want %0d", first_out - first_acc, DEPTH); end
    vectors++; if (first_dat !== 8'h01) begin miscompares++; $display("FAIL lat first_data: got %h want 01", first_dat); end
  endtask

  task automatic test_backpressure();
    int idx;
    int k;
    logic ordy;
    logic acc;
    idx = 0;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      ordy = (c >= 4);
      if (idx < 4) drive(1'b1, WIDTH'(8'h10 + idx), ordy, 1'b0);
      else         drive(1'b0, '0, ordy, 1'b0);
      model_eval();
      if (c == 3) begin
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp full in_ready: got %b want 0", bus.in_ready); end
        vectors++; if (bus.count !== 2'd3) begin miscompares++; $display("FAIL bp full count: got %0d want 3", bus.count); end
      end
      vectors++; if (bus.in_ready !== exp_in_ready) begin miscompares++; $display("FAIL bp in_ready: got %b want %b", bus.in_ready, exp_in_ready); end
      vectors++; if (bus.out_valid !== exp_out_valid) begin miscompares++; $display("FAIL bp out_valid: got %b want %b", bus.out_valid, exp_out_valid); end
      vectors++; if (bus.count !== exp_count) begin miscompares++; $display("FAIL bp count: got %0d want %0d", bus.count, exp_count); end
      if (bus.out_valid === 1'b1 && ordy) begin
        vectors++; if (bus.out_data !== WIDTH'(8'h10 + k)) begin miscompares++; $display("FAIL bp order: got %h want %h", bus.out_data, WIDTH'(8'h10 + k)); end
        k++;
      end
      acc = bus.in_valid && exp_in_ready;
      clock_edge();
      if (acc) idx++;
    end
    vectors++; if (k != 4) begin miscompares++; $display("FAIL bp emerged: got %0d want 4", k); end
  endtask

  task automatic test_full_pop_push();
    int acc_cyc;
    int seen;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, WIDTH'($urandom_range(0, 15)), 1'b0, 1'b0);
      clock_edge();
    end
    drive(1'b1, 8'h20, 1'b1, 1'b0);
    vectors++; if (bus.count !== 2'd3) begin miscompares++; $display("FAIL fpp pre count: got %0d want 3", bus.count); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL fpp in_ready: got %b want 1", bus.in_ready); end
    acc_cyc = edge_n;
    clock_edge();
    drive(1'b0, '0, 1'b1, 1'b0);
    vectors++; if (bus.count !== 2'd3) begin miscompares++; $display("FAIL fpp post count: got %0d want 3", bus.count); end
    seen = -1;
    for (int c = 0; c < 8; c++) begin
      model_eval();
      if (seen < 0 && bus.out_valid === 1'b1 && bus.out_data === 8'h20) seen = edge_n;
      vectors++; if (bus.out_valid !== exp_out_valid) begin miscompares++; $display("FAIL fpp out_valid: got %b want %b", bus.out_valid, exp_out_valid); end
      if (exp_out_valid) begin
        vectors++; if (bus.out_data !== exp_out_data) begin miscompares++; $display("FAIL fpp out_data: got %h want %h", bus.out_data, exp_out_data); end
      end
      clock_edge();
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    vectors++; if (seen - acc_cyc != DEPTH) begin miscompares++; $display("FAIL fpp latency_20: got %0d want %0d", seen - acc_cyc, DEPTH); end
  endtask

  task automatic test_flush();
    drive(1'b1, WIDTH'($urandom_range(0, 15)), 1'b0, 1'b0);
    clock_edge();
    drive(1'b1, WIDTH'($urandom_range(0, 15)), 1'b0, 1'b0);
    clock_edge();
    drive(1'b0, '0, 1'b0, 1'b0);
    clock_edge();
    drive(1'b1, 8'h30, 1'b0, 1'b1);
    vectors++; if (bus.count !== 2'd2) begin miscompares++; $display("FAIL flush pre count: got %0d want 2", bus.count); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL flush in_ready: got %b want 0", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL flush cycle out_valid: got %b want 1", bus.out_valid); end
    clock_edge();
    drive(1'b0, '0, 1'b1, 1'b0);
    vectors++; if (bus.count !== 2'd0) begin miscompares++; $display("FAIL flush post count: got %0d want 0", bus.count); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush post out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_data !== RV) begin miscompares++; $display("FAIL flush post out_data: got %h want %h", bus.out_data, RV); end
    for (int c = 0; c < 5; c++) begin
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush ghost out_valid: got %b (data %h) want 0", bus.out_valid, bus.out_data); end
      clock_edge();
      drive(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_bubble_collapse();
    drive(1'b1, 8'h40, 1'b0, 1'b0);
    clock_edge();
    drive(1'b0, '0, 1'b0, 1'b0);
    clock_edge();
    drive(1'b1, 8'h41, 1'b0, 1'b0);
    clock_edge();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      model_eval();
      vectors++; if (bus.count !== exp_count) begin miscompares++; $display("FAIL bub count: got %0d want %0d", bus.count, exp_count); end
      vectors++; if (bus.in_ready !== exp_in_ready) begin miscompares++; $display("FAIL bub in_ready: got %b want %b", bus.in_ready, exp_in_ready); end
      clock_edge();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    vectors++; if (bus.count !== 2'd2) begin miscompares++; $display("FAIL bub held count: got %0d want 2", bus.count); end
    vectors++; if (bus.out_data !== 8'h40 || bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL bub head: got v=%b %h want v=1 40", bus.out_valid, bus.out_data); end
    drive(1'b0, '0, 1'b1, 1'b0);
    clock_edge();
    drive(1'b0, '0, 1'b1, 1'b0);
    vectors++; if (bus.out_data !== 8'h41 || bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL bub back_to_back: got v=%b %h want v=1 41", bus.out_valid, bus.out_data); end
    clock_edge();
    drive(1'b0, '0, 1'b1, 1'b0);
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bub drained out_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_random();
    logic v;
    logic ordy;
    logic fl;
    for (int c = 0; c < 400; c++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = (c < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      fl   = ($urandom_range(0, 31) == 0);
      drive(v, WIDTH'($urandom), ordy, fl);
      model_eval();
      vectors++; if (bus.in_ready !== exp_in_ready) begin miscompares++; $display("FAIL rnd in_ready @%0d: got %b want %b", c, bus.in_ready, exp_in_ready); end
      vectors++; if (bus.out_valid !== exp_out_valid) begin miscompares++; $display("FAIL rnd out_valid @%0d: got %b want %b", c, bus.out_valid, exp_out_valid); end
      vectors++; if (bus.count !== exp_count) begin miscompares++; $display("FAIL rnd count @%0d: got %0d want %0d", c, bus.count, exp_count); end
      if (exp_out_valid) begin
        vectors++; if (bus.out_data !== exp_out_data) begin miscompares++; $display("FAIL rnd out_data @%0d: got %h want %h", c, bus.out_data, exp_out_data); end
      end
      clock_edge();
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    vectors       = 0;
    miscompares   = 0;
    edge_n        = 0;
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    test_reset();
    test_latency_throughput();
    test_backpressure();
    test_full_pop_push();
    test_flush();
    test_bubble_collapse();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
